// File: rtl/reg_serializer_pkg.sv
// Shared types and constants for the ALU result-register serializer.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } ser_state_t;

    // Level driven on ser_out when no data bit is on the line.
    localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/reg_serializer_if.sv
// Word-in handshake plus serial-out bundle between the ALU result register and the serializer.
interface reg_serializer_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_start, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_start, busy, done
    );

endinterface

// File: rtl/reg_serializer_shift_reg_piso.sv
// Single-bit dff cell and the parallel-load, shift-right register built from it.
module dff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

endmodule

module shift_reg_piso
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;

    // NOTE: q_next is defaulted before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_next = q;
        if (load)       q_next = d;
        else if (shift) q_next = {SER_IDLE_BIT, q[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff u_dff (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (q_next[i]),
            .q    (q[i])
        );
    end

    assign q0 = q[0];

endmodule

// File: rtl/reg_serializer.sv
// LSB-first serializer for one WIDTH-bit word per handshake.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module reg_serializer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    ser_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             handshake;
    logic             last_bit;
    logic             shift_q0;

    logic in_ready_q, ser_valid_q, frame_start_q, busy_q, done_q;

    assign handshake = bus.in_valid & in_ready_q;
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = DONE;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY:  state_next = DONE;
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready_q    <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            in_ready_q    <= (state_next == IDLE);
            ser_valid_q   <= (state_next == SHIFT) || (state_next == PARITY);
            frame_start_q <= handshake;
            busy_q        <= (state_next != IDLE);
            done_q        <= (state_next == DONE);
        end
    end

    // The final SHIFT edge shifts in the idle fill, so q0 is already idle by DONE.
    shift_reg_piso #(.WIDTH(WIDTH)) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (handshake),
        .shift(state == SHIFT),
        .d    (bus.in_data),
        .q0   (shift_q0)
    );

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         parity_q <= 1'b0;
        else if (handshake) parity_q <= ^bus.in_data;
    end

    assign bus.ser_out = (state == PARITY) ? parity_q : shift_q0;
`else
    assign bus.ser_out = shift_q0;
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Directed-vector bench for reg_serializer; a negedge monitor records the serial stream.
module tb_reg_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int PERIOD = FRAME_BITS + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_serializer_if #(.WIDTH(WIDTH)) bus ();

    reg_serializer #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int fs_cyc = 0;
    int done_cyc = 0;
    logic bits_q[$];
    logic fs_q[$];
    int   hs_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.ser_valid) begin
            bits_q.push_back(bus.ser_out);
            fs_q.push_back(bus.frame_start);
        end
        if (bus.frame_start) fs_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.in_valid && bus.in_ready) hs_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        bits_q.delete();
        fs_q.delete();
        hs_q.delete();
        done_cnt = 0;
    endtask

    function automatic logic [31:0] packed_bits();
        logic [31:0] v = '0;
        for (int k = 0; k < bits_q.size() && k < 32; k++) v[k] = bits_q[k];
        return v;
    endfunction

    function automatic int fs_ones();
        int n = 0;
        foreach (fs_q[k]) n += int'(fs_q[k]);
        return n;
    endfunction

    // Presents a word and returns one cycle after the handshake edge (bit 0 on the line).
    task automatic send(input logic [WIDTH-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%b, required 1 for word %h", bus.in_ready, w);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 100 && done_cnt < n; i++) tick();
        vectors++;
        if (done_cnt < n) begin
            miscompares++;
            $display("FAIL done_timeout: done pulses %0d, required %0d", done_cnt, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.in_ready, bus.ser_out, bus.ser_valid, bus.frame_start, bus.busy, bus.done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {bus.in_ready, bus.ser_out, bus.ser_valid, bus.frame_start, bus.busy, bus.done});
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b, required 0", bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b, required 1", bus.in_ready);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_release: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_single();
        clear_mon();
        send(8'hA5);
        wait_done(1);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_done_idle: in_ready=%b done=%b, required 1 0", bus.in_ready, bus.done);
        end
        vectors++;
        if (bits_q.size() != FRAME_BITS) begin
            miscompares++;
            $display("FAIL a5_len: got %0d bits, required %0d", bits_q.size(), FRAME_BITS);
        end
        vectors++;
        if (packed_bits() !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL a5_stream: got %h, required 000000a5", packed_bits());
        end
        vectors++;
        if (fs_ones() != 1 || fs_q.size() == 0 || fs_q[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_frame_start: high on %0d bits, required 1 (first bit)", fs_ones());
        end
        vectors++;
        if (done_cyc - fs_cyc != FRAME_BITS) begin
            miscompares++;
            $display("FAIL a5_done_latency: got %0d, required %0d", done_cyc - fs_cyc, FRAME_BITS);
        end
        repeat (3) tick();
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL a5_done_width: done high %0d cycles, required 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < 50 && hs_q.size() < 1; i++) tick();
        bus.in_data = 8'h00;
        for (int i = 0; i < 50 && hs_q.size() < 2; i++) tick();
        bus.in_valid = 1'b0;
        wait_done(2);
        vectors++;
        if (hs_q.size() != 2 || hs_q[1] - hs_q[0] != PERIOD) begin
            miscompares++;
            $display("FAIL b2b_spacing: %0d handshakes, spacing %0d, required 2 and %0d",
                     hs_q.size(), (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1, PERIOD);
        end
        vectors++;
        if (bits_q.size() != 2 * FRAME_BITS) begin
            miscompares++;
            $display("FAIL b2b_len: got %0d bits, required %0d", bits_q.size(), 2 * FRAME_BITS);
        end
        vectors++;
        if (packed_bits() !== 32'h0000_00FF) begin
            miscompares++;
            $display("FAIL b2b_stream: got %h, required 000000ff", packed_bits());
        end
    endtask

    task automatic test_ignore();
        clear_mon();
        send(8'h81);
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        wait_done(1);
        repeat (4) tick();
        vectors++;
        if (bits_q.size() != FRAME_BITS || packed_bits() !== 32'h0000_0081) begin
            miscompares++;
            $display("FAIL ignore_stream: got %h (%0d bits), required 00000081 (%0d bits)",
                     packed_bits(), bits_q.size(), FRAME_BITS);
        end
        vectors++;
        if (hs_q.size() != 1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_no_queue: %0d handshakes busy=%b, required 1 and 0", hs_q.size(), bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send(8'hF0);
        repeat (4) tick();
        vectors++;
        if (bus.ser_valid !== 1'b1 || bus.ser_out !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_bit4: ser_valid=%b ser_out=%b, required 1 1", bus.ser_valid, bus.ser_out);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.ser_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_abort: ser_valid=%b busy=%b, required 0 0", bus.ser_valid, bus.busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL midreset_done: got %0d done pulses, required 0", done_cnt);
        end
        clear_mon();
        send(8'h0F);
        wait_done(1);
        vectors++;
        if (bits_q.size() != FRAME_BITS || packed_bits() !== 32'h0000_000F) begin
            miscompares++;
            $display("FAIL midreset_recover: got %h (%0d bits), required 0000000f", packed_bits(), bits_q.size());
        end
    endtask

`ifdef SERIALIZER_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send(8'h07);
        wait_done(1);
        vectors++;
        if (bits_q.size() != 9 || bits_q[8] !== 1'b1 || packed_bits() !== 32'h0000_0107) begin
            miscompares++;
            $display("FAIL parity_07: got %h (%0d bits), required 00000107 (9 bits)", packed_bits(), bits_q.size());
        end
        vectors++;
        if (done_cyc - fs_cyc != WIDTH + 1) begin
            miscompares++;
            $display("FAIL parity_latency: got %0d, required %0d", done_cyc - fs_cyc, WIDTH + 1);
        end
        vectors++;
        if (fs_ones() != 1) begin
            miscompares++;
            $display("FAIL parity_frame_start: high on %0d bits, required 1", fs_ones());
        end
        clear_mon();
        send(8'h03);
        wait_done(1);
        vectors++;
        if (bits_q.size() != 9 || bits_q[8] !== 1'b0 || packed_bits() !== 32'h0000_0003) begin
            miscompares++;
            $display("FAIL parity_03: got %h (%0d bits), required 00000003 (9 bits)", packed_bits(), bits_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
`ifdef SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
